// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared opcode/funct3 constants, the memory-stage state type,
// and the alignment rule used by the memory stage.
package riscv_mem_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   // Byte accesses never misalign; halfwords need addr[0]=0; everything else
   // (word and unrecognised sizes, which behave as words) needs addr[1:0]=0.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
      case (funct3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return addr_lo[0];
         default:     return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: EX/MEM memory request and memory-stage response bundle.
// master = pipeline side (drives the request), slave = memory stage.
interface mem_stage_ctrl_if;

   logic [6:0]  EXMEM_opcode_out;
   logic [2:0]  EXMEM_funct3_out;
   logic [31:0] EXMEM_data_addr_out;
   logic [3:0]  EXMEM_data_write_byte_out;
   logic [31:0] EXMEM_data_write_out;
   logic        EXMEM_register_write_valid_out;

   logic        mem_stall;
   logic        mem_read_valid;
   logic [31:0] mem_read_data;
   logic        mem_misalign;

   modport master (
      output EXMEM_opcode_out, EXMEM_funct3_out, EXMEM_data_addr_out,
             EXMEM_data_write_byte_out, EXMEM_data_write_out,
             EXMEM_register_write_valid_out,
      input  mem_stall, mem_read_valid, mem_read_data, mem_misalign
   );

   modport slave (
      input  EXMEM_opcode_out, EXMEM_funct3_out, EXMEM_data_addr_out,
             EXMEM_data_write_byte_out, EXMEM_data_write_out,
             EXMEM_register_write_valid_out,
      output mem_stall, mem_read_valid, mem_read_data, mem_misalign
   );

endinterface

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword from a memory word and
// sign- or zero-extends it according to funct3. Purely combinational.
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select followed by extension; unknown sizes return the full word.
   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   result = {24'h0, byte_sel};
         F3_H:    result = {{16{half_sel[15]}}, half_sel};
         F3_HU:   result = {16'h0, half_sel};
         F3_W:    result = word;
         default: result = word;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage responder for the EX/MEM load/store request.
// Holds the pipeline for WAIT_CYCLES+1 cycles per access, then responds.
// Build macro DMEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and
// are reported on mem_misalign (loads return 0); undefined -> mem_misalign is 0.
//
// state | meaning
// IDLE  | nothing in flight; a live request is latched here
// WAIT  | counting down wait states on the latched request
// RESP  | load result valid; store lanes committed on the exit edge
module mem_stage_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   mem_stage_ctrl_if.slave bus
);

   localparam int         AW        = DEPTH_LOG2 + 2;
   localparam int         WORDS     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

   mem_state_t    state;
   logic [3:0]    cnt;
   logic [AW-1:0] addr_q;
   logic [2:0]    funct3_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          load_q;
   logic          read_valid_q;
   logic [31:0]   read_data_q;
   logic          misalign_q;

   logic [31:0]   mem_q [WORDS];

   logic          req_load;
   logic          req_store;
   logic          req;
   logic [AW-1:0] acc_addr;
   logic [2:0]    acc_funct3;
   logic          acc_load;
   logic          acc_misalign;
   logic          enter_resp;
   logic [31:0]   rd_word;
   logic [31:0]   ext_word;
   logic          unused_addr_hi;

   assign req_load  = (bus.EXMEM_opcode_out == OPC_LOAD) && bus.EXMEM_register_write_valid_out;
   assign req_store = (bus.EXMEM_opcode_out == OPC_STORE) && (|bus.EXMEM_data_write_byte_out);
   assign req       = req_load || req_store;

   // Address bits above the array wrap away.
   assign unused_addr_hi = ^bus.EXMEM_data_addr_out[31:AW];

   assign bus.mem_stall      = ((state == IDLE) && req) || (state == WAIT);
   assign bus.mem_read_valid = read_valid_q;
   assign bus.mem_read_data  = read_data_q;
   assign bus.mem_misalign   = misalign_q;

   // Read-port source: live inputs on a zero-wait accept, latched request otherwise.
   always_comb begin
      if (state == IDLE) begin
         acc_addr   = bus.EXMEM_data_addr_out[AW-1:0];
         acc_funct3 = bus.EXMEM_funct3_out;
         acc_load   = req_load;
      end else begin
         acc_addr   = addr_q;
         acc_funct3 = funct3_q;
         acc_load   = load_q;
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign acc_misalign = is_misaligned(acc_funct3, acc_addr[1:0]);
`else
   assign acc_misalign = 1'b0;
`endif

   assign enter_resp = ((state == IDLE) && req && ZERO_WAIT) ||
                       ((state == WAIT) && (cnt == 4'd1));

   assign rd_word = mem_q[acc_addr[AW-1:2]];

   load_extend u_load_extend (
      .word    (rd_word),
      .addr_lo (acc_addr[1:0]),
      .funct3  (acc_funct3),
      .result  (ext_word)
   );

   // Access sequencer with registered load response and misalign flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         addr_q       <= '0;
         funct3_q     <= 3'd0;
         be_q         <= 4'd0;
         wdata_q      <= 32'd0;
         load_q       <= 1'b0;
         read_valid_q <= 1'b0;
         read_data_q  <= 32'd0;
         misalign_q   <= 1'b0;
      end else begin
         read_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         if (enter_resp) begin
            read_valid_q <= acc_load;
            misalign_q   <= acc_misalign;
            if (acc_load) begin
               read_data_q <= acc_misalign ? 32'd0 : ext_word;
            end
         end
         case (state)
            IDLE: begin
               if (req) begin
                  addr_q   <= bus.EXMEM_data_addr_out[AW-1:0];
                  funct3_q <= bus.EXMEM_funct3_out;
                  be_q     <= bus.EXMEM_data_write_byte_out;
                  wdata_q  <= bus.EXMEM_data_write_out;
                  load_q   <= req_load;
                  cnt      <= WAIT_INIT;
                  state    <= ZERO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Store commit on the RESP -> IDLE edge; trapped stores leave memory alone.
   always_ff @(posedge clk) begin
      if ((state == RESP) && !load_q && !misalign_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
               mem_q[addr_q[AW-1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage responder for the pipelined RISC-V core. Consumes the load/store request held in the EX/MEM pipeline register, performs the access on an internal byte-lane data memory with configurable wait states, stalls the pipeline until the access completes, and returns aligned, sign/zero-extended load data toward MEM/WB. It is the consumer end of the EX/MEM memory-request interface.

## Interface
Reset is asynchronous and active-low; one clock.
- DEPTH_LOG2, 10: data memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: extra wait states per access, 0..15.
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- EXMEM_opcode_out  input  7  instruction opcode; 7'b0000011 load, 7'b0100011 store
- EXMEM_funct3_out  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- EXMEM_data_addr_out  input  32  byte address
- EXMEM_data_write_byte_out  input  4  store byte-lane enables, already lane-aligned; 0 = squashed store
- EXMEM_data_write_out  input  32  store data, already lane-aligned
- EXMEM_register_write_valid_out  input  1  load is live; 0 = squashed load
- mem_stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
- mem_read_valid  output  1  load data valid this cycle
- mem_read_data  output  32  extended load result
- mem_misalign  output  1  misaligned access flagged (see Configuration)

## Operation
- Request: load = load opcode & register_write_valid; store = store opcode & write_byte != 0. Anything else is ignored, no stall.
- FSM states IDLE, WAIT, RESP.
- IDLE: on request, latch addr, funct3, byte enables, write data, kind; counter <= WAIT_CYCLES; go WAIT if WAIT_CYCLES != 0, else RESP.
- WAIT: counter decrements each cycle; when counter == 1 on a clock edge, go RESP.
- RESP: for a store, write enabled lanes of word addr[DEPTH_LOG2+1:2] on the RESP->IDLE edge. For a load, mem_read_data/mem_read_valid are registered on entry to RESP. Always RESP -> IDLE.
- Load extraction: B/BU select byte addr[1:0]; H/HU select halfword addr[1]; W full word; B/H sign-extend, BU/HU zero-extend. Other funct3 values are treated as W.
- Address bits above DEPTH_LOG2+1 are ignored (wrap modulo memory size).
- mem_read_data holds its last load value until the next load response; mem_read_valid is high only in RESP for loads.

## Timing
- mem_stall = (IDLE & request) | WAIT. It is combinational, so the same request stays on the inputs until RESP. It is low in RESP, so EX/MEM advances at the end of RESP.
- Access occupies WAIT_CYCLES+2 cycles: the IDLE accept cycle, the WAIT cycles, and the RESP cycle. Back-to-back requests are accepted in the IDLE cycle following RESP.
- Reset values: state IDLE, counter 0, mem_stall 0, mem_read_valid 0, mem_read_data 0, mem_misalign 0. Memory array is not reset.
- Reset asserted mid-access returns to IDLE immediately. A pending store is discarded and memory is unchanged.
- Latched request is used from accept onward; input changes during WAIT are ignored.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0, performs no memory access. In RESP, mem_misalign=1 for one cycle, and for a load mem_read_valid=1 with mem_read_data=0.
- Not defined: mem_misalign tied 0. Low address bits beyond the lane select are ignored, and the access proceeds on the selected word.

## Structure
- Package riscv_mem_pkg: opcode constants LOAD/STORE, funct3 constants, mem_state_t enum {IDLE, WAIT, RESP}.
- Sub-module load_extend: combinational word + addr[1:0] + funct3 -> extended 32-bit result. It is reused by any future load path.
- Memory array is inferred inside mem_stage_ctrl with per-lane write enables.

## Test plan
- Store then load, WAIT_CYCLES=2: SW 0xDEADBEEF at 0x40 (lanes 1111), then LW 0x40 -> mem_stall high for 3 cycles each, mem_read_data=0xDEADBEEF in RESP.
- Byte extension: after the store above, LB 0x43 -> 0xFFFFFFDE; LBU 0x43 -> 0x000000DE; LH 0x40 -> 0xFFFFBEEF; LHU 0x42 -> 0x0000DEAD.
- Partial store: SB lanes 0100, data 0x00550000 at 0x40, then LW 0x40 -> 0xDE55BEEF.
- Squash: store opcode with write_byte=0, and load with register_write_valid=0 -> mem_stall stays 0, memory unchanged, mem_read_valid stays 0.
- Reset mid-access: assert rst_n=0 during WAIT of SW 0x11111111 to 0x40 -> outputs go to 0 immediately, then LW 0x40 still returns 0xDE55BEEF.
- With DMEM_MISALIGN_TRAP_EN: LW 0x42 -> mem_misalign=1 and mem_read_data=0 in RESP; without it -> returns word at 0x40.
